mem_request_unit: RTL

Parametrised successor to the single-entry request unit. Arbitrates instruction fetches and a queue of up to DEPTH buffered data requests onto one shared memory port, holding each request stable until the memory acknowledges it. Returns one-cycle hit pulses and read data to the pipeline. Sits between the datapath (fetch and memory stages) and the memory controller; it lets the memory stage post stores and loads without stalling fetch on every access.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/request_fifo.sv | 60 ++++++
 rtl/mem_request_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, request-unit FSM states, queued data-request entry.
// Pure type/constant package; no logic and no latency of its own.
// Backpressure: not applicable.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Memory request unit arbitration states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2
    } mru_state_t;

    // Buffered data request at the default 32-bit address/data width
    typedef struct packed {
        logic  wen;
        word_t addr;
        word_t wdata;
    } dreq_entry_t;

    // Fairness bit encoding: which request type completed last
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/request_fifo.sv
// Synchronous FIFO of data-request entries exposing head, full, empty and occupancy count.
// Latency: a pushed entry is visible at the head (count updated) the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; simultaneous push+pop keeps count.
module request_fifo
    import cpu_types_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = dreq_entry_t
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       i_push,
    input  entry_t                     i_push_dat,
    input  logic                       i_pop,
    output entry_t                     o_head_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/mem_request_unit.sv
// Arbitrates fetches and queued data requests onto one memory port; optional watchdog via REQ_TIMEOUT_EN.
// Latency: enqueue at t -> strobes from t+2; mem_ack at k -> hit/rdata at k+1, next strobes from k+2.
// Backpressure: dreq_ready = !full (a same-cycle pop does not free a slot); requests held until mem_ack.
module mem_request_unit
    import cpu_types_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       imemreq,
    input  logic [ADDR_W-1:0]          imemaddr,
    input  logic                       dreq_valid,
    output logic                       dreq_ready,
    input  logic                       dreq_wen,
    input  logic [ADDR_W-1:0]          dreq_addr,
    input  logic [DATA_W-1:0]          dreq_wdata,
    output logic                       ihit,
    output logic                       dhit,
    output logic                       dhit_wen,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       mem_ren,
    output logic                       mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       req_err
);

    // Same layout as dreq_entry_t, sized by this instance's parameters
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    mru_state_t         r_state;
    logic               r_last_grant;
    logic               r_mem_ren;
    logic               r_mem_wen;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_ihit;
    logic               r_dhit;
    logic               r_dhit_wen;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_req_err;

    entry_t             w_push_dat;
    entry_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_grant_d;
    logic               w_expire;

    assign w_push_dat = '{wen: dreq_wen, addr: dreq_addr, wdata: dreq_wdata};

    request_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_push     (dreq_valid),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (pending)
    );

    // Data wins when it is alone, or on a conflict when the last completion was a fetch
    assign w_grant_d = !w_empty && (!imemreq || (r_last_grant == GRANT_I));
    // The head leaves the queue only when its memory transaction finishes (ack or abort)
    assign w_pop     = (r_state == DREQ) && (mem_ack || w_expire);

`ifdef REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Watchdog: held at zero while idle so each request starts counting from zero
    always_ff @(posedge CLK) begin
        if (!nRST || (r_state == IDLE)) begin
            r_to_cnt <= '0;
        end else if (!mem_ack) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Expiry after TIMEOUT_CYCLES strobe cycles; a same-cycle ack takes precedence
    assign w_expire = (r_state != IDLE) && !mem_ack && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_expire         = 1'b0;
`endif

    // Arbitration FSM with registered memory strobes and one-cycle completion pulses
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ihit       <= 1'b0;
            r_dhit       <= 1'b0;
            r_dhit_wen   <= 1'b0;
            r_rdata      <= '0;
            r_req_err    <= 1'b0;
        end else begin
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_dhit_wen <= 1'b0;
            r_req_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= DREQ;
                        r_mem_ren   <= !w_head.wen;
                        r_mem_wen   <= w_head.wen;
                        r_mem_addr  <= w_head.addr;
                        r_mem_wdata <= w_head.wdata;
                    end else if (imemreq) begin
                        r_state     <= IREQ;
                        r_mem_ren   <= 1'b1;
                        r_mem_wen   <= 1'b0;
                        r_mem_addr  <= imemaddr;
                        r_mem_wdata <= '0;
                    end
                end
                IREQ: begin
                    if (mem_ack || w_expire) begin
                        r_state      <= IDLE;
                        r_mem_ren    <= 1'b0;
                        r_mem_wen    <= 1'b0;
                        r_last_grant <= GRANT_I;
                        if (mem_ack) begin
                            r_rdata <= mem_rdata;
                            // A fetch withdrawn before its ack completes without a hit
                            r_ihit  <= imemreq;
                        end else begin
                            r_req_err <= 1'b1;
                        end
                    end
                end
                DREQ: begin
                    if (mem_ack || w_expire) begin
                        r_state      <= IDLE;
                        r_mem_ren    <= 1'b0;
                        r_mem_wen    <= 1'b0;
                        r_last_grant <= GRANT_D;
                        if (mem_ack) begin
                            r_rdata    <= mem_rdata;
                            r_dhit     <= 1'b1;
                            r_dhit_wen <= r_mem_wen;
                        end else begin
                            r_req_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_ren <= 1'b0;
                    r_mem_wen <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_ready = !w_full;
    assign ihit       = r_ihit;
    assign dhit       = r_dhit;
    assign dhit_wen   = r_dhit_wen;
    assign rdata      = r_rdata;
    assign mem_ren    = r_mem_ren;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign req_err    = r_req_err;

endmodule
